// File: rtl/triumph_wb_stage_if.sv
// Memory-stage to writeback-stage retire handshake.
// Master is the memory stage, slave is triumph_wb_stage.
interface triumph_wb_stage_if;
  logic        valid_mem_i;
  logic        ready_mem_o;
  logic        rd_we_mem_i;
  logic [4:0]  rd_addr_mem_i;
  logic        is_load_mem_i;
  logic [2:0]  load_type_mem_i;
  logic [31:0] result_mem_i;

  modport master (
    output valid_mem_i,
    output rd_we_mem_i,
    output rd_addr_mem_i,
    output is_load_mem_i,
    output load_type_mem_i,
    output result_mem_i,
    input  ready_mem_o
  );

  modport slave (
    input  valid_mem_i,
    input  rd_we_mem_i,
    input  rd_addr_mem_i,
    input  is_load_mem_i,
    input  load_type_mem_i,
    input  result_mem_i,
    output ready_mem_o
  );
endinterface

// File: rtl/triumph_wb_stage.sv
// Triumph writeback stage: load wait/align, registered RF write port.
// Optional macro TRIUMPH_WB_FWD_EN adds next-edge forwarding outputs.
module triumph_wb_stage #(
  parameter int unsigned LOAD_TIMEOUT = 16,
  parameter int unsigned XLEN         = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  triumph_wb_stage_if.slave mem,
  input  logic             data_rvalid_i,
  input  logic [XLEN-1:0]  data_rdata_i,
  output logic             data_valid_wb_o,
  output logic [4:0]       rd_addr_wb_o,
  output logic [XLEN-1:0]  rd_data_wb_o,
  output logic             stall_o,
  output logic             misaligned_o,
  output logic             timeout_o
`ifdef TRIUMPH_WB_FWD_EN
  ,
  output logic             fwd_valid_o,
  output logic [4:0]       fwd_addr_o,
  output logic [XLEN-1:0]  fwd_data_o
`endif
);

  typedef enum logic {
    S_IDLE,
    S_WAIT_LOAD
  } state_e;

  localparam logic [7:0] CntLast = 8'(LOAD_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic [2:0]      ld_type_q, ld_type_d;
  logic [1:0]      ld_off_q, ld_off_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            mis_q, mis_d;
  logic            tmo_q, tmo_d;
  logic            ready;
  logic            stall;

  function automatic logic is_misaligned(
    input logic [2:0] t,
    input logic [1:0] off
  );
    logic m;
    m = 1'b1;
    unique case (t)
      3'b000, 3'b100: m = 1'b0;
      3'b001, 3'b101: m = off[0];
      3'b010:         m = |off;
      default:        m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [XLEN-1:0] align_load(
    input logic [2:0]      t,
    input logic [1:0]      off,
    input logic [XLEN-1:0] w
  );
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    unique case (t)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_rd_d    = ld_rd_q;
    ld_type_d  = ld_type_q;
    ld_off_d   = ld_off_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    mis_d      = 1'b0;
    tmo_d      = tmo_q;
    ready      = 1'b0;
    stall      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (mem.valid_mem_i) begin
          if (!mem.is_load_mem_i) begin
            wb_valid_d = mem.rd_we_mem_i &&
                         (mem.rd_addr_mem_i != 5'd0);
            if (wb_valid_d) begin
              wb_addr_d = mem.rd_addr_mem_i;
              wb_data_d = mem.result_mem_i;
            end
          end else if (is_misaligned(mem.load_type_mem_i,
                                     mem.result_mem_i[1:0])) begin
            mis_d = 1'b1;
          end else begin
            state_d   = S_WAIT_LOAD;
            cnt_d     = 8'd0;
            ld_rd_d   = mem.rd_addr_mem_i;
            ld_type_d = mem.load_type_mem_i;
            ld_off_d  = mem.result_mem_i[1:0];
          end
        end
      end
      S_WAIT_LOAD: begin
        stall = 1'b1;
        if (data_rvalid_i) begin
          state_d    = S_IDLE;
          wb_valid_d = (ld_rd_q != 5'd0);
          if (wb_valid_d) begin
            wb_addr_d = ld_rd_q;
            wb_data_d = align_load(ld_type_q, ld_off_q, data_rdata_i);
          end
        end else if (cnt_q == CntLast) begin
          // Abandon the load; the flag stays until reset.
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      ld_rd_q    <= 5'd0;
      ld_type_q  <= 3'd0;
      ld_off_q   <= 2'd0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= 5'd0;
      wb_data_q  <= '0;
      mis_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_rd_q    <= ld_rd_d;
      ld_type_q  <= ld_type_d;
      ld_off_q   <= ld_off_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      mis_q      <= mis_d;
      tmo_q      <= tmo_d;
    end
  end

  assign mem.ready_mem_o  = ready;
  assign stall_o          = stall;
  assign data_valid_wb_o  = wb_valid_q;
  assign rd_addr_wb_o     = wb_addr_q;
  assign rd_data_wb_o     = wb_data_q;
  assign misaligned_o     = mis_q;
  assign timeout_o        = tmo_q;

`ifdef TRIUMPH_WB_FWD_EN
  assign fwd_valid_o = wb_valid_d;
  assign fwd_addr_o  = wb_addr_d;
  assign fwd_data_o  = wb_data_d;
`endif

endmodule

// File: tb/tb_triumph_wb_stage.sv
// Scoreboard bench for triumph_wb_stage: random ALU/load traffic.
// Expected writebacks and misaligned pulses are queued, a monitor pops.
module tb_triumph_wb_stage;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        dv;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall;
  logic        mis;
  logic        tmo;
`ifdef TRIUMPH_WB_FWD_EN
  logic        fwd_v;
  logic [4:0]  fwd_a;
  logic [31:0] fwd_d;
`endif

  always #5 clk = ~clk;

  triumph_wb_stage_if mif();

  triumph_wb_stage #(.LOAD_TIMEOUT(T), .XLEN(32)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .mem             (mif),
    .data_rvalid_i   (rvalid),
    .data_rdata_i    (rdata),
    .data_valid_wb_o (dv),
    .rd_addr_wb_o    (wb_addr),
    .rd_data_wb_o    (wb_data),
    .stall_o         (stall),
    .misaligned_o    (mis),
    .timeout_o       (tmo)
`ifdef TRIUMPH_WB_FWD_EN
    ,
    .fwd_valid_o     (fwd_v),
    .fwd_addr_o      (fwd_a),
    .fwd_data_o      (fwd_d)
`endif
  );

  typedef struct {
    bit          is_mis;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   tmo_exp = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference load result: shift the word right by the byte offset,
  // then extend the low byte/half according to funct3.
  function automatic logic [31:0] model_load(
    input logic [2:0] t, input logic [1:0] off, input logic [31:0] w
  );
    logic [31:0]        sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    sh  = w >> (8 * int'(off));
    sb  = sh[7:0];
    shw = sh[15:0];
    case (t)
      3'd0:    return 32'(sb);
      3'd1:    return 32'(shw);
      3'd4:    return sh & 32'h0000_00ff;
      3'd5:    return sh & 32'h0000_ffff;
      default: return w;
    endcase
  endfunction

  function automatic bit model_mis(input logic [2:0] t, input logic [1:0] off);
    int o;
    o = int'(off);
    if (t == 3'd0 || t == 3'd4) return 1'b0;
    if (t == 3'd1 || t == 3'd5) return (o % 2) != 0;
    if (t == 3'd2) return o != 0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (dv) begin
        if (q.size() == 0 || q[0].is_mis) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_wb: got rd=%0d data=%h required none",
                   wb_addr, wb_data);
        end else begin
          e = q.pop_front();
          chk("wb_addr", 32'(wb_addr), 32'(e.a));
          chk("wb_data", wb_data, e.d);
        end
      end
      if (mis) begin
        if (q.size() == 0 || !q[0].is_mis) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_misaligned: got 1 required 0");
        end else begin
          e = q.pop_front();
          chk("misaligned", 32'(mis), 32'd1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alu(bit we, logic [4:0] rd, logic [31:0] r);
    mif.valid_mem_i     = 1'b1;
    mif.is_load_mem_i   = 1'b0;
    mif.rd_we_mem_i     = we;
    mif.rd_addr_mem_i   = rd;
    mif.result_mem_i    = r;
    mif.load_type_mem_i = 3'($urandom);
    rvalid              = 1'($urandom);
    rdata               = $urandom;
    chk("alu_ready", 32'(mif.ready_mem_o), 32'd1);
    chk("alu_stall", 32'(stall), 32'd0);
    if (we && rd != 5'd0) q.push_back('{1'b0, rd, r});
    step();
    mif.valid_mem_i = 1'b0;
    rvalid          = 1'b0;
  endtask

  task automatic do_load(logic [2:0] t, logic [4:0] rd, logic [31:0] addr,
                         logic [31:0] w, int dly, bit respond);
    bit m;
    m = model_mis(t, addr[1:0]);
    mif.valid_mem_i     = 1'b1;
    mif.is_load_mem_i   = 1'b1;
    mif.rd_we_mem_i     = 1'b1;
    mif.rd_addr_mem_i   = rd;
    mif.result_mem_i    = addr;
    mif.load_type_mem_i = t;
    rvalid              = 1'b0;
    chk("ld_ready", 32'(mif.ready_mem_o), 32'd1);
    if (m) q.push_back('{1'b1, 5'd0, 32'd0});
    step();
    mif.valid_mem_i   = 1'b0;
    mif.is_load_mem_i = 1'b0;
    if (m) begin
      chk("mis_ready", 32'(mif.ready_mem_o), 32'd1);
      chk("mis_stall", 32'(stall), 32'd0);
      return;
    end
    chk("ld_tmo_before", 32'(tmo), 32'(tmo_exp));
    if (respond) begin
      for (int i = 0; i < dly; i++) begin
        chk("wait_stall", 32'(stall), 32'd1);
        chk("wait_ready", 32'(mif.ready_mem_o), 32'd0);
        rdata = $urandom;
        step();
      end
      rvalid = 1'b1;
      rdata  = w;
      chk("resp_stall", 32'(stall), 32'd1);
      if (rd != 5'd0) q.push_back('{1'b0, rd, model_load(t, addr[1:0], w)});
      step();
      rvalid = 1'b0;
      chk("after_ready", 32'(mif.ready_mem_o), 32'd1);
      chk("after_stall", 32'(stall), 32'd0);
    end else begin
      for (int i = 0; i < T; i++) begin
        chk("to_stall", 32'(stall), 32'd1);
        step();
      end
      tmo_exp = 1'b1;
      chk("to_stall_end", 32'(stall), 32'd0);
      chk("to_ready", 32'(mif.ready_mem_o), 32'd1);
      chk("to_flag", 32'(tmo), 32'd1);
    end
  endtask

  task automatic chk_reset_outputs(string nm);
    chk({nm, "_dv"}, 32'(dv), 32'd0);
    chk({nm, "_addr"}, 32'(wb_addr), 32'd0);
    chk({nm, "_data"}, wb_data, 32'd0);
    chk({nm, "_stall"}, 32'(stall), 32'd0);
    chk({nm, "_mis"}, 32'(mis), 32'd0);
    chk({nm, "_tmo"}, 32'(tmo), 32'd0);
    chk({nm, "_ready"}, 32'(mif.ready_mem_o), 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    mif.valid_mem_i     = 1'b0;
    mif.is_load_mem_i   = 1'b0;
    mif.rd_we_mem_i     = 1'b0;
    mif.rd_addr_mem_i   = 5'd0;
    mif.load_type_mem_i = 3'd0;
    mif.result_mem_i    = 32'd0;
    rvalid              = 1'b0;
    rdata               = 32'd0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();

    do_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
    do_load(3'd0, 5'd7, 32'h0000_0103, 32'h80FF_1234, 3, 1'b1);
    do_load(3'd4, 5'd7, 32'h0000_0103, 32'h80FF_1234, 0, 1'b1);
    do_load(3'd1, 5'd9, 32'h0000_0202, 32'h9ABC_0000, 1, 1'b1);
    do_load(3'd5, 5'd9, 32'h0000_0201, 32'h9ABC_0000, 1, 1'b1);
    do_alu(1'b1, 5'd0, 32'h1234_5678);
    do_load(3'd2, 5'd0, 32'h0000_0400, 32'hCAFE_F00D, 2, 1'b1);
    do_load(3'd2, 5'd4, 32'h0000_0400, 32'hCAFE_F00D, T - 1, 1'b1);
    do_load(3'd3, 5'd4, 32'h0000_0400, 32'h0, 0, 1'b1);
    do_load(3'd2, 5'd6, 32'h0000_0800, 32'h0, 0, 1'b0);
    do_alu(1'b1, 5'd6, 32'h0BAD_CAFE);
    do_alu(1'b1, 5'd31, 32'hFFFF_FFFF);
    do_alu(1'b0, 5'd3, 32'h5555_AAAA);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_alu(1'($urandom), 5'($urandom), $urandom);
      end else begin
        do_load(3'($urandom), 5'($urandom), $urandom, $urandom,
                $urandom_range(0, T - 1), $urandom_range(0, 24) != 0);
      end
    end

    do_load(3'd2, 5'd3, 32'h0000_1000, 32'h0, 0, 1'b0);
    step();
    mif.valid_mem_i     = 1'b1;
    mif.is_load_mem_i   = 1'b1;
    mif.load_type_mem_i = 3'd2;
    mif.rd_addr_mem_i   = 5'd3;
    mif.result_mem_i    = 32'h0000_2000;
    step();
    mif.valid_mem_i   = 1'b0;
    mif.is_load_mem_i = 1'b0;
    step();
    chk("midload_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    tmo_exp = 1'b0;
    chk_reset_outputs("midload_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rvalid = 1'b1;
    rdata  = 32'h7777_7777;
    chk("post_reset_ready", 32'(mif.ready_mem_o), 32'd1);
    step();
    rvalid = 1'b0;
    do_alu(1'b1, 5'd12, 32'h0000_00C0);
    step();
    step();
    step();
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("final_tmo", 32'(tmo), 32'(tmo_exp));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
